// File: rtl/soft_tbm_pkg.sv
// Shared definitions for the soft TBM trigger sequencer: event-word bit
// positions, sequencer state encoding and a small event-word helper.
package soft_tbm_pkg;

    localparam int EVT_SYN = 0;
    localparam int EVT_TRG = 1;
    localparam int EVT_RSR = 2;
    localparam int EVT_RST = 3;
    localparam int EVT_CAL = 4;
    localparam int EVT_W   = 5;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_RST    = 4'd1;
    localparam logic [3:0] ST_RSR    = 4'd2;
    localparam logic [3:0] ST_SETTLE = 4'd3;
    localparam logic [3:0] ST_SYNC   = 4'd4;
    localparam logic [3:0] ST_CAL    = 4'd5;
    localparam logic [3:0] ST_CALDLY = 4'd6;
    localparam logic [3:0] ST_TRG    = 4'd7;
    localparam logic [3:0] ST_GAP    = 4'd8;
    localparam logic [3:0] ST_FIN    = 4'd9;

    // Keeps only the lowest set bit so a host word can never break the one-hot rule.
    function automatic logic [EVT_W-1:0] lowest_bit(input logic [EVT_W-1:0] v);
        return v & (~v + 5'd1);
    endfunction

endpackage

// File: rtl/soft_tbm_slot_timer.sv
// Loadable down-counter that advances once per non-stalled sync slot and
// flags zero; times the SETTLE, CALDLY and GAP idle stretches.
module soft_tbm_slot_timer #(
    parameter int W = 17
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         sync_i,
    input  logic         stall_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (sync_i && !stall_i) begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/soft_tbm_trigger_seq.sv
// Trigger scheduler for the soft TBM: reset preamble, then periodic cal/trg
// bursts with syncs, host events merged with priority. Optional random gap
// jitter is built when SOFT_TBM_TRGSEQ_RANDOM_GAP_EN is defined.
module soft_tbm_trigger_seq
    import soft_tbm_pkg::*;
#(
    parameter logic [7:0] SETTLE = 8'd32,
    parameter int         CW     = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          sync,
    input  logic          start,
    input  logic          stop,
    input  logic          cfg_rst,
    input  logic          cfg_rsr,
    input  logic          cfg_cal,
    input  logic [7:0]    cfg_cal_dly,
    input  logic [CW-1:0] cfg_period,
    input  logic [CW-1:0] cfg_count,
    input  logic [7:0]    cfg_syn_every,
`ifdef SOFT_TBM_TRGSEQ_RANDOM_GAP_EN
    input  logic [7:0]    cfg_jitter_mask,
`endif
    input  logic [4:0]    ext_evt,
    output logic [4:0]    evt,
    output logic          running,
    output logic          done,
    output logic [CW-1:0] trg_cnt
);

    localparam int TW = CW + 1;

    logic [3:0]    state_q, state_d;
    logic [4:0]    evt_q, evt_d;
    logic          running_q, running_d;
    logic          done_q, done_d;
    logic [CW-1:0] trg_cnt_q, trg_cnt_d;
    logic [7:0]    syn_cnt_q, syn_cnt_d;
    logic          stop_pend_q, stop_pend_d;

    logic          cfg_rst_q;
    logic          cfg_rsr_q;
    logic          cfg_cal_q;
    logic [7:0]    cfg_cal_dly_q;
    logic [CW-1:0] cfg_period_q;
    logic [CW-1:0] cfg_count_q;
    logic [7:0]    cfg_syn_every_q;

    logic          stall;
    logic          cfg_load;
    logic          syn_hit;
    logic [3:0]    eff_state;
    logic [CW-1:0] trg_inc;
    logic          run_over;
    logic [TW-1:0] gap_len;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_zero;

    assign stall    = (ext_evt != '0);
    assign cfg_load = !stall && (state_q == ST_IDLE) && start;
    assign trg_inc  = trg_cnt_q + 1'b1;
    assign run_over = ((cfg_count_q != '0) && (trg_inc == cfg_count_q))
                      || stop_pend_q || (stop && running_q);

    // syn_cnt_q tracks trg_cnt modulo cfg_syn_every without a divider.
    assign syn_hit = (cfg_syn_every_q != 8'd0) && (syn_cnt_q == 8'd0);

    // A SYNC slot with no syn to send collapses into the following state.
    always_comb begin
        eff_state = state_q;
        if (state_q == ST_SYNC && !syn_hit) begin
            eff_state = cfg_cal_q ? ST_CAL : ST_TRG;
        end
    end

`ifdef SOFT_TBM_TRGSEQ_RANDOM_GAP_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic [7:0]  jit_mask_q;
    logic        trg_step;

    assign trg_step = !stall && (eff_state == ST_TRG);
    assign gap_len  = {1'b0, cfg_period_q} + TW'(lfsr_q[7:0] & jit_mask_q);

    always_comb begin
        lfsr_d = lfsr_q;
        if (trg_step) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q     <= 16'hACE1;
            jit_mask_q <= '0;
        end else if (sync) begin
            lfsr_q <= lfsr_d;
            if (cfg_load) begin
                jit_mask_q <= cfg_jitter_mask;
            end
        end
    end
`else
    assign gap_len = {1'b0, cfg_period_q};
`endif

    always_comb begin
        state_d     = state_q;
        evt_d       = '0;
        done_d      = 1'b0;
        running_d   = running_q;
        trg_cnt_d   = trg_cnt_q;
        syn_cnt_d   = syn_cnt_q;
        stop_pend_d = stop_pend_q | (stop & running_q);
        tmr_load    = 1'b0;
        tmr_val     = '0;
        if (stall) begin
            evt_d = lowest_bit(ext_evt);
        end else begin
            case (eff_state)
                ST_IDLE: begin
                    if (start) begin
                        trg_cnt_d   = '0;
                        syn_cnt_d   = '0;
                        stop_pend_d = 1'b0;
                        running_d   = 1'b1;
                        if (cfg_rst) begin
                            state_d = ST_RST;
                        end else if (cfg_rsr) begin
                            state_d = ST_RSR;
                        end else begin
                            state_d = ST_SYNC;
                        end
                    end
                end
                ST_RST: begin
                    evt_d[EVT_RST] = 1'b1;
                    if (cfg_rsr_q) begin
                        state_d = ST_RSR;
                    end else begin
                        state_d  = (SETTLE == 8'd0) ? ST_SYNC : ST_SETTLE;
                        tmr_load = (SETTLE != 8'd0);
                        tmr_val  = TW'(SETTLE) - 1'b1;
                    end
                end
                ST_RSR: begin
                    evt_d[EVT_RSR] = 1'b1;
                    state_d  = (SETTLE == 8'd0) ? ST_SYNC : ST_SETTLE;
                    tmr_load = (SETTLE != 8'd0);
                    tmr_val  = TW'(SETTLE) - 1'b1;
                end
                ST_SETTLE: begin
                    if (tmr_zero) begin
                        state_d = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    evt_d[EVT_SYN] = 1'b1;
                    state_d = cfg_cal_q ? ST_CAL : ST_TRG;
                end
                ST_CAL: begin
                    evt_d[EVT_CAL] = 1'b1;
                    if (cfg_cal_dly_q == 8'd0) begin
                        state_d = ST_TRG;
                    end else begin
                        state_d  = ST_CALDLY;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(cfg_cal_dly_q) - 1'b1;
                    end
                end
                ST_CALDLY: begin
                    if (tmr_zero) begin
                        state_d = ST_TRG;
                    end
                end
                ST_TRG: begin
                    evt_d[EVT_TRG] = 1'b1;
                    trg_cnt_d = trg_inc;
                    // Restart the modulo count on wrap so syn stays aligned to trg_cnt==0.
                    if (trg_inc == '0 || (syn_cnt_q + 8'd1) == cfg_syn_every_q) begin
                        syn_cnt_d = '0;
                    end else begin
                        syn_cnt_d = syn_cnt_q + 8'd1;
                    end
                    if (run_over) begin
                        state_d = ST_FIN;
                    end else if (gap_len == '0) begin
                        state_d = ST_SYNC;
                    end else begin
                        state_d  = ST_GAP;
                        tmr_load = 1'b1;
                        tmr_val  = gap_len - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (tmr_zero) begin
                        state_d = ST_SYNC;
                    end
                end
                ST_FIN: begin
                    done_d      = 1'b1;
                    running_d   = 1'b0;
                    stop_pend_d = 1'b0;
                    state_d     = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            evt_q       <= '0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            trg_cnt_q   <= '0;
            syn_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
        end else if (sync) begin
            state_q     <= state_d;
            evt_q       <= evt_d;
            running_q   <= running_d;
            done_q      <= done_d;
            trg_cnt_q   <= trg_cnt_d;
            syn_cnt_q   <= syn_cnt_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    // Run configuration is frozen at start so host writes mid-run have no effect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_rst_q       <= 1'b0;
            cfg_rsr_q       <= 1'b0;
            cfg_cal_q       <= 1'b0;
            cfg_cal_dly_q   <= '0;
            cfg_period_q    <= '0;
            cfg_count_q     <= '0;
            cfg_syn_every_q <= '0;
        end else if (sync && cfg_load) begin
            cfg_rst_q       <= cfg_rst;
            cfg_rsr_q       <= cfg_rsr;
            cfg_cal_q       <= cfg_cal;
            cfg_cal_dly_q   <= cfg_cal_dly;
            cfg_period_q    <= cfg_period;
            cfg_count_q     <= cfg_count;
            cfg_syn_every_q <= cfg_syn_every;
        end
    end

    soft_tbm_slot_timer #(
        .W (TW)
    ) u_slot_timer (
        .clk_i      (clk),
        .rst_ni     (reset_n),
        .sync_i     (sync),
        .stall_i    (stall),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    assign evt     = evt_q;
    assign running = running_q;
    assign done    = done_q;
    assign trg_cnt = trg_cnt_q;

endmodule

// File: tb/tb_soft_tbm_trigger_seq.sv
// Randomized bench for soft_tbm_trigger_seq: builds the expected slot stream
// from the run rules and compares it every clock, including non-sync holds.
module tb_soft_tbm_trigger_seq;

    localparam int CW           = 16;
    localparam int SETTLE_SLOTS = 32;

    localparam logic [4:0] EV_NONE = 5'b00000;
    localparam logic [4:0] EV_SYN  = 5'b00001;
    localparam logic [4:0] EV_TRG  = 5'b00010;
    localparam logic [4:0] EV_RSR  = 5'b00100;
    localparam logic [4:0] EV_RST  = 5'b01000;
    localparam logic [4:0] EV_CAL  = 5'b10000;

    logic          clk;
    logic          reset_n;
    logic          sync;
    logic          start;
    logic          stop;
    logic          cfg_rst;
    logic          cfg_rsr;
    logic          cfg_cal;
    logic [7:0]    cfg_cal_dly;
    logic [CW-1:0] cfg_period;
    logic [CW-1:0] cfg_count;
    logic [7:0]    cfg_syn_every;
`ifdef SOFT_TBM_TRGSEQ_RANDOM_GAP_EN
    logic [7:0]    cfg_jitter_mask;
`endif
    logic [4:0]    ext_evt;
    logic [4:0]    evt;
    logic          running;
    logic          done;
    logic [CW-1:0] trg_cnt;

    typedef struct {
        logic [4:0]  evt;
        logic        done;
        logic        running;
        logic [15:0] cnt;
    } slot_t;

    slot_t       expQ[$];
    slot_t       cur;
    logic [15:0] lastCnt;
    int          checks = 0;
    int          errors = 0;

    soft_tbm_trigger_seq #(
        .SETTLE (8'd32),
        .CW     (CW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .sync            (sync),
        .start           (start),
        .stop            (stop),
        .cfg_rst         (cfg_rst),
        .cfg_rsr         (cfg_rsr),
        .cfg_cal         (cfg_cal),
        .cfg_cal_dly     (cfg_cal_dly),
        .cfg_period      (cfg_period),
        .cfg_count       (cfg_count),
        .cfg_syn_every   (cfg_syn_every),
`ifdef SOFT_TBM_TRGSEQ_RANDOM_GAP_EN
        .cfg_jitter_mask (cfg_jitter_mask),
`endif
        .ext_evt         (ext_evt),
        .evt             (evt),
        .running         (running),
        .done            (done),
        .trg_cnt         (trg_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkSlot();
        checkOutput("evt", 32'(evt), 32'(cur.evt));
        checkOutput("done", 32'(done), 32'(cur.done));
        checkOutput("running", 32'(running), 32'(cur.running));
        checkOutput("trg_cnt", 32'(trg_cnt), 32'(cur.cnt));
    endtask

    task automatic clearCur();
        cur.evt     = EV_NONE;
        cur.done    = 1'b0;
        cur.running = 1'b0;
        cur.cnt     = 16'd0;
        lastCnt     = 16'd0;
    endtask

    task automatic pushSlot(input logic [4:0] e, input logic d, input logic r, input int c);
        slot_t s;
        s.evt     = e;
        s.done    = d;
        s.running = r;
        s.cnt     = 16'(c);
        expQ.push_back(s);
    endtask

    // Expected slot stream for one run, starting with the slot that carries start.
    task automatic buildModel(input bit rst, input bit rsr, input bit cal, input int calDly,
                              input int period, input int count, input int synEvery, input int stopSlot);
        int n;
        bit fin;
        expQ.delete();
        n = 0;
        pushSlot(EV_NONE, 1'b0, 1'b1, 0);
        if (rst) pushSlot(EV_RST, 1'b0, 1'b1, 0);
        if (rsr) pushSlot(EV_RSR, 1'b0, 1'b1, 0);
        if (rst || rsr) repeat (SETTLE_SLOTS) pushSlot(EV_NONE, 1'b0, 1'b1, 0);
        fin = 1'b0;
        while (!fin) begin
            if (synEvery != 0 && (n % synEvery) == 0) pushSlot(EV_SYN, 1'b0, 1'b1, n);
            if (cal) begin
                pushSlot(EV_CAL, 1'b0, 1'b1, n);
                repeat (calDly) pushSlot(EV_NONE, 1'b0, 1'b1, n);
            end
            n++;
            pushSlot(EV_TRG, 1'b0, 1'b1, n);
            if ((count != 0 && n == count) || (stopSlot >= 1 && stopSlot <= expQ.size() - 1) || n > 200) begin
                fin = 1'b1;
            end else begin
                repeat (period) pushSlot(EV_NONE, 1'b0, 1'b1, n);
            end
        end
        pushSlot(EV_NONE, 1'b1, 1'b0, n);
        repeat (2) pushSlot(EV_NONE, 1'b0, 1'b0, n);
        lastCnt = 16'(n);
    endtask

    // A host event takes over one slot; everything after it slides by one slot.
    task automatic injectModel(input int slot, input logic [4:0] e);
        slot_t s;
        s.evt = EV_NONE;
        for (int i = 0; i < 5; i++) begin
            if (e[i] && s.evt == EV_NONE) s.evt[i] = 1'b1;
        end
        s.done    = 1'b0;
        s.running = expQ[slot-1].running;
        s.cnt     = expQ[slot-1].cnt;
        expQ.insert(slot, s);
    endtask

    task automatic fillIdle(input int n);
        expQ.delete();
        repeat (n) pushSlot(EV_NONE, 1'b0, 1'b0, 32'(lastCnt));
    endtask

    task automatic setCfg(input bit rst, input bit rsr, input bit cal, input int calDly,
                          input int period, input int count, input int synEvery);
        cfg_rst       = rst;
        cfg_rsr       = rsr;
        cfg_cal       = cal;
        cfg_cal_dly   = 8'(calDly);
        cfg_period    = 16'(period);
        cfg_count     = 16'(count);
        cfg_syn_every = 8'(synEvery);
`ifdef SOFT_TBM_TRGSEQ_RANDOM_GAP_EN
        cfg_jitter_mask = 8'h00;
`endif
    endtask

    task automatic scrambleCfg();
        cfg_rst       = ($urandom_range(0, 1) == 1);
        cfg_rsr       = ($urandom_range(0, 1) == 1);
        cfg_cal       = ($urandom_range(0, 1) == 1);
        cfg_cal_dly   = 8'($urandom_range(0, 255));
        cfg_period    = 16'($urandom_range(0, 65535));
        cfg_count     = 16'($urandom_range(0, 65535));
        cfg_syn_every = 8'($urandom_range(0, 255));
`ifdef SOFT_TBM_TRGSEQ_RANDOM_GAP_EN
        cfg_jitter_mask = 8'($urandom_range(0, 255));
`endif
    endtask

    task automatic doReset();
        sync    = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        ext_evt = EV_NONE;
        reset_n = 1'b1;
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("reset_evt", 32'(evt), 32'(EV_NONE));
        checkOutput("reset_running", 32'(running), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_trg_cnt", 32'(trg_cnt), 0);
        @(negedge clk);
        reset_n = 1'b1;
        clearCur();
    endtask

    // Plays expQ against the DUT with random sync gaps and junk on non-sync cycles.
    task automatic applyStimulus(input bit doStart, input int stopSlot, input int injSlot,
                                 input logic [4:0] injEvt, input int abortSlot);
        int slotIdx = 0;
        int cyc = 0;
        bit s;
        while (expQ.size() != 0) begin
            if (cyc >= 4000) begin
                checkOutput("cycle_budget", 32'(expQ.size()), 0);
                break;
            end
            @(negedge clk);
            if (abortSlot >= 0 && slotIdx == abortSlot) begin
                sync    = 1'b0;
                start   = 1'b0;
                stop    = 1'b0;
                ext_evt = EV_NONE;
                reset_n = 1'b0;
                #2;
                checkOutput("abort_evt", 32'(evt), 32'(EV_NONE));
                checkOutput("abort_running", 32'(running), 0);
                checkOutput("abort_done", 32'(done), 0);
                checkOutput("abort_trg_cnt", 32'(trg_cnt), 0);
                @(negedge clk);
                reset_n = 1'b1;
                expQ.delete();
                clearCur();
                break;
            end
            s = ($urandom_range(0, 3) != 0);
            sync = s;
            if (s) begin
                start   = doStart && (slotIdx == 0);
                stop    = (slotIdx == stopSlot);
                ext_evt = (slotIdx == injSlot) ? injEvt : EV_NONE;
            end else begin
                start   = ($urandom_range(0, 1) == 1);
                stop    = ($urandom_range(0, 1) == 1);
                ext_evt = 5'($urandom_range(0, 31));
            end
            @(posedge clk);
            #1;
            if (s) begin
                cur = expQ.pop_front();
                slotIdx++;
                if (slotIdx == 1) scrambleCfg();
            end
            checkSlot();
            cyc++;
        end
        @(negedge clk);
        sync    = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        ext_evt = EV_NONE;
    endtask

`ifdef SOFT_TBM_TRGSEQ_RANDOM_GAP_EN
    int gapsA[$];
    int gapsB[$];

    task automatic collectGaps(input int which);
        int slotIdx = 0;
        int lastTrg = -1;
        int g;
        setCfg(0, 0, 0, 0, 4, 6, 0);
        cfg_jitter_mask = 8'h03;
        while (slotIdx < 2000) begin
            @(negedge clk);
            sync    = 1'b1;
            start   = (slotIdx == 0);
            stop    = 1'b0;
            ext_evt = EV_NONE;
            @(posedge clk);
            #1;
            slotIdx++;
            if (evt == EV_TRG) begin
                if (lastTrg >= 0) begin
                    g = slotIdx - lastTrg - 1;
                    if (which == 0) gapsA.push_back(g);
                    else gapsB.push_back(g);
                    checkOutput("jitter_gap_range", 32'(g >= 4 && g <= 7), 1);
                end
                lastTrg = slotIdx;
            end
            if (done) break;
        end
        checkOutput("jitter_done_seen", 32'(done), 1);
        @(negedge clk);
        sync = 1'b0;
    endtask
`endif

    initial begin
        int calDly, period, count, synEvery, mode, stopSlot, injSlot;
        bit rst, rsr, cal;
        logic [4:0] injEvt;

        setCfg(0, 0, 0, 0, 0, 0, 0);
        doReset();

        // Preamble run: rst, rsr, settle, two triggers spaced by three idle slots.
        setCfg(1, 1, 0, 0, 3, 2, 0);
        buildModel(1, 1, 0, 0, 3, 2, 0, -1);
        applyStimulus(1, -1, -1, EV_NONE, -1);

        // Back-to-back cal bursts with syn before every second trigger.
        setCfg(0, 0, 1, 2, 0, 3, 2);
        buildModel(0, 0, 1, 2, 0, 3, 2, -1);
        applyStimulus(1, -1, -1, EV_NONE, -1);

        // Host rsr lands inside the cal delay and stretches it by one slot.
        setCfg(0, 0, 1, 2, 0, 1, 0);
        buildModel(0, 0, 1, 2, 0, 1, 0, -1);
        injectModel(2, EV_RSR);
        applyStimulus(1, -1, 2, EV_RSR, -1);

        // Unlimited run stopped in a cal slot still finishes its trigger.
        setCfg(0, 0, 1, 1, 1, 0, 0);
        buildModel(0, 0, 1, 1, 1, 0, 0, 5);
        applyStimulus(1, 5, -1, EV_NONE, -1);

        // Multi-bit host word while idle passes only its lowest bit.
        fillIdle(3);
        injectModel(1, 5'b10110);
        applyStimulus(0, -1, 1, 5'b10110, -1);

        // Reset during a gap, then idle with no done, then a clean restart.
        setCfg(0, 0, 0, 0, 5, 3, 0);
        buildModel(0, 0, 0, 0, 5, 3, 0, -1);
        applyStimulus(1, -1, -1, EV_NONE, 4);
        fillIdle(6);
        applyStimulus(0, -1, -1, EV_NONE, -1);
        setCfg(0, 0, 1, 2, 0, 3, 2);
        buildModel(0, 0, 1, 2, 0, 3, 2, -1);
        applyStimulus(1, -1, -1, EV_NONE, -1);

        for (int r = 0; r < 25; r++) begin
            rst      = ($urandom_range(0, 1) == 1);
            rsr      = ($urandom_range(0, 1) == 1);
            cal      = ($urandom_range(0, 1) == 1);
            calDly   = $urandom_range(0, 3);
            period   = $urandom_range(0, 4);
            count    = $urandom_range(0, 4);
            synEvery = $urandom_range(0, 3);
            mode     = (count == 0) ? 1 : $urandom_range(0, 2);
            stopSlot = (mode == 1) ? $urandom_range(1, 40) : -1;
            setCfg(rst, rsr, cal, calDly, period, count, synEvery);
            buildModel(rst, rsr, cal, calDly, period, count, synEvery, stopSlot);
            injSlot = -1;
            injEvt  = EV_NONE;
            if (mode == 2) begin
                injSlot = $urandom_range(1, expQ.size() - 1);
                injEvt  = 5'($urandom_range(1, 31));
                injectModel(injSlot, injEvt);
            end
            applyStimulus(1, stopSlot, injSlot, injEvt, -1);
        end

`ifdef SOFT_TBM_TRGSEQ_RANDOM_GAP_EN
        doReset();
        collectGaps(0);
        doReset();
        collectGaps(1);
        checkOutput("jitter_gap_count", 32'(gapsB.size()), 32'(gapsA.size()));
        for (int i = 0; i < gapsA.size() && i < gapsB.size(); i++) begin
            checkOutput("jitter_repeat", 32'(gapsB[i]), 32'(gapsA[i]));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/soft_tbm_trigger_seq.md
Name: soft_tbm_trigger_seq

Overview:
- Programmable trigger scheduler that sequences a soft TBM.
- Generates the 5-bit event word {cal, rst, rsr, trg, syn} that drives the soft TBM's trg_in_tbm input.
- Issues an optional reset preamble, then periodic cal/trg bursts with periodic syncs.
- Merges host-issued direct events into the same stream with priority over the sequencer.

Parameters:
- SETTLE, 8'd32: idle sync slots inserted after the reset preamble.
- CW, 16: width of the period, count and trigger-counter fields.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- sync  in  1  clock enable; one event slot per cycle with sync high
- start  in  1  pulse, sampled on a sync cycle; begins a run
- stop  in  1  pulse, sampled on a sync cycle; ends the run after the current burst
- cfg_rst  in  1  send rst in the preamble
- cfg_rsr  in  1  send rsr in the preamble
- cfg_cal  in  1  precede each trg with cal
- cfg_cal_dly  in  8  idle slots between cal and trg
- cfg_period  in  CW  idle slots after each trg
- cfg_count  in  CW  triggers per run; 0 = unlimited
- cfg_syn_every  in  8  syn before every Nth trigger; 0 = never
- ext_evt  in  5  direct host events, valid on sync cycles
- evt  out  5  event word {cal, rst, rsr, trg, syn}
- running  out  1  sequencer active
- done  out  1  one-sync-slot pulse at run end
- trg_cnt  out  CW  triggers issued in the current run

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- Timing: all state and outputs update only on cycles with sync high. evt is registered and holds for exactly one sync period, so each event is seen by the soft TBM exactly once.
- One-hot rule: evt has at most one bit set per slot.
- ext_evt arbitration:
  - Any nonzero ext_evt wins the slot and is output as-is (lowest set bit only if several bits are set).
  - The sequencer stalls for that slot: no state change, countdowns frozen.
- Configuration: cfg_* is latched on start; changes mid-run are ignored.
- State machine:
  - IDLE: on start, trg_cnt←0 and running←1, then go to RST if cfg_rst, else RSR if cfg_rsr, else SYNC.
  - RST: emit rst; go to RSR if cfg_rsr, else SETTLE.
  - RSR: emit rsr; go to SETTLE.
  - SETTLE: SETTLE idle slots; go to SYNC. This state is entered only after a preamble event.
  - SYNC: if cfg_syn_every≠0 and trg_cnt mod cfg_syn_every==0, emit syn, else the slot is skipped in zero slots. Then go to CAL if cfg_cal, else TRG.
  - CAL: emit cal; go to CALDLY.
  - CALDLY: cfg_cal_dly idle slots (0 = trg in the next slot); go to TRG.
  - TRG: emit trg, trg_cnt+1. Go to FIN if (cfg_count≠0 and trg_cnt+1==cfg_count) or stop is pending; else GAP.
  - GAP: cfg_period idle slots; go to SYNC.
  - FIN: done=1 for one slot, running←0; go to IDLE.
- Boundary conditions:
  - stop sets a pending flag. In CAL/CALDLY the cal-trg pair still completes. In IDLE stop is ignored.
  - start while running is ignored.
  - trg_cnt wraps at 2^CW only in unlimited mode.
  - cfg_period=0 gives back-to-back bursts: trg, syn/cal, trg…
  - reset_n low mid-run aborts immediately with no done pulse.

Optional Feature:
- Macro SOFT_TBM_TRGSEQ_RANDOM_GAP_EN.
- Defined:
  - A 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) steps each TRG slot.
  - GAP length = cfg_period + (lfsr[7:0] & cfg_jitter_mask).
  - Adds input port cfg_jitter_mask, 8 bits, latched on start.
- Undefined: port absent; GAP length = cfg_period exactly.

Decomposition:
- Shared package soft_tbm_pkg:
  - Event bit indices EVT_SYN=0, EVT_TRG=1, EVT_RSR=2, EVT_RST=3, EVT_CAL=4.
  - State encoding constants.
- Sub-module soft_tbm_slot_timer: loadable down-counter gated by sync and a stall input, with a zero flag. Used for SETTLE, CALDLY and GAP.

Test Plan:
- cfg_rst=1, cfg_rsr=1, cfg_cal=0, period=3, count=2, syn_every=0, start → evt: rst, rsr, 32 idle, trg, 3 idle, trg, then done; trg_cnt=2.
- cfg_cal=1, cal_dly=2, period=0, count=3, syn_every=2 → syn, cal, 2 idle, trg, cal, 2 idle, trg, syn, cal, 2 idle, trg, done.
- ext_evt=5'b00100 injected during a CALDLY slot → evt=rsr that slot; cal-to-trg spacing stretches by exactly 1 slot.
- count=0, period=1; stop asserted in a CAL slot → the pending trg still issues, then FIN/done; no further cal.
- reset_n low during GAP → evt=0, running=0, done never pulses; the next start restarts with trg_cnt=0.
- RANDOM_GAP_EN, mask=8'h03, period=4 → every gap length is in 4..7; the sequence is identical across two runs from reset.
